// File: rtl/tmds_encoder_3ch.sv
// Three-channel TMDS 8b/10b encoder (blue/green/red), DC-balanced, latency 2+OUT_REG.
// Optional macro TMDS_PATTERN_EN adds pattern_en, which swaps the pixel inputs for an 8-bit ramp.
module tmds_encoder_3ch #(
  parameter int unsigned OUT_REG = 1,
  parameter logic [1:0]  CTRL_G  = 2'b00,
  parameter logic [1:0]  CTRL_R  = 2'b00
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       de,
  input  logic       hsync,
  input  logic       vsync,
`ifdef TMDS_PATTERN_EN
  input  logic       pattern_en,
`endif
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  output logic [9:0] r,
  output logic [9:0] g,
  output logic [9:0] b,
  output logic       de_out
);

  localparam logic [9:0] TOKEN_00 = 10'h354;

  function automatic logic [8:0] stage1(input logic [7:0] d);
    logic [3:0] n;
    logic       use_xnor;
    logic [8:0] q;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) n = n + {3'b000, d[i]};
    use_xnor = (n > 4'd4) || (n == 4'd4 && !d[0]);
    q    = '0;
    q[0] = d[0];
    for (int unsigned i = 1; i < 8; i++)
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  // Returns {next_cnt[4:0], symbol[9:0]} for one active pixel.
  function automatic logic [14:0] encode(input logic [8:0] qm, input logic signed [4:0] cnt);
    logic signed [4:0] n1;
    logic signed [4:0] n0;
    logic signed [4:0] nc;
    logic [9:0]        s;
    n1 = '0;
    for (int unsigned i = 0; i < 8; i++) n1 = n1 + {4'b0000, qm[i]};
    n0 = 5'sd8 - n1;
    if (cnt == 0 || n1 == n0) begin
      s  = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      nc = qm[8] ? (cnt + n1 - n0) : (cnt + n0 - n1);
    end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
      s  = {1'b1, qm[8], ~qm[7:0]};
      nc = cnt + (qm[8] ? 5'sd2 : 5'sd0) + n0 - n1;
    end else begin
      s  = {1'b0, qm[8], qm[7:0]};
      nc = cnt + n1 - n0 - (qm[8] ? 5'sd0 : 5'sd2);
    end
    return {nc, s};
  endfunction

  function automatic logic [9:0] token(input logic [1:0] c);
    case (c)
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  // Channel index: 0 = blue, 1 = green, 2 = red.
  logic [7:0] pix [3];

`ifdef TMDS_PATTERN_EN
  logic [7:0] ramp;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)  ramp <= '0;
    else if (de)  ramp <= ramp + 8'd1;
    else          ramp <= '0;
  end

  always_comb begin
    pix[0] = pattern_en ? ramp : b_in;
    pix[1] = pattern_en ? ramp : g_in;
    pix[2] = pattern_en ? ramp : r_in;
  end
`else
  always_comb begin
    pix[0] = b_in;
    pix[1] = g_in;
    pix[2] = r_in;
  end
`endif

  logic [8:0] qm [3];
  logic       de1;
  logic [1:0] sync1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned c = 0; c < 3; c++) qm[c] <= '0;
      de1   <= 1'b0;
      sync1 <= '0;
    end else begin
      for (int unsigned c = 0; c < 3; c++) qm[c] <= stage1(pix[c]);
      de1   <= de;
      sync1 <= {vsync, hsync};
    end
  end

  logic signed [4:0] cnt [3];
  logic [9:0]        sym [3];
  logic              de2;
  logic [1:0]        ctl [3];
  logic [14:0]       enc [3];

  always_comb begin
    ctl[0] = sync1;
    ctl[1] = CTRL_G;
    ctl[2] = CTRL_R;
    for (int unsigned c = 0; c < 3; c++) enc[c] = encode(qm[c], cnt[c]);
  end

  // Blanking clears disparity so the first pixel after de rises starts balanced.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned c = 0; c < 3; c++) begin
        cnt[c] <= '0;
        sym[c] <= TOKEN_00;
      end
      de2 <= 1'b0;
    end else begin
      de2 <= de1;
      for (int unsigned c = 0; c < 3; c++) begin
        if (de1) begin
          sym[c] <= enc[c][9:0];
          cnt[c] <= enc[c][14:10];
        end else begin
          sym[c] <= token(ctl[c]);
          cnt[c] <= '0;
        end
      end
    end
  end

  logic [9:0] sym_o [3];
  logic       de_o;

  if (OUT_REG != 0) begin : g_out_reg
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        for (int unsigned c = 0; c < 3; c++) sym_o[c] <= TOKEN_00;
        de_o <= 1'b0;
      end else begin
        for (int unsigned c = 0; c < 3; c++) sym_o[c] <= sym[c];
        de_o <= de2;
      end
    end
  end else begin : g_out_comb
    always_comb begin
      for (int unsigned c = 0; c < 3; c++) sym_o[c] = sym[c];
      de_o = de2;
    end
  end

  assign b      = sym_o[0];
  assign g      = sym_o[1];
  assign r      = sym_o[2];
  assign de_out = de_o;

endmodule

// File: tb/tb_tmds_encoder_3ch.sv
// Directed self-checking bench for tmds_encoder_3ch (OUT_REG=1, latency 3).
module tb_tmds_encoder_3ch;
  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       resetn, de, hsync, vsync;
  logic [7:0] r_in, g_in, b_in;
  logic [9:0] r, g, b;
  logic       de_out;
`ifdef TMDS_PATTERN_EN
  logic       pattern_en = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  logic [9:0] cap_r[$], cap_g[$], cap_b[$];
  logic       cap_de[$];

  tmds_encoder_3ch #(.OUT_REG(1), .CTRL_G(2'b00), .CTRL_R(2'b00)) dut (
    .clk(clk), .resetn(resetn), .de(de), .hsync(hsync), .vsync(vsync),
`ifdef TMDS_PATTERN_EN
    .pattern_en(pattern_en),
`endif
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .r(r), .g(g), .b(b), .de_out(de_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference TMDS data decoder, independent of the encoder structure.
  function automatic logic [7:0] dec(input logic [9:0] s);
    logic [7:0] q, d;
    q    = s[9] ? ~s[7:0] : s[7:0];
    d    = '0;
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  task automatic step(input logic d, input logic hs, input logic vs,
                      input logic [7:0] rv, input logic [7:0] gv, input logic [7:0] bv);
    de = d; hsync = hs; vsync = vs; r_in = rv; g_in = gv; b_in = bv;
    @(posedge clk); #1;
    cap_r.push_back(r); cap_g.push_back(g); cap_b.push_back(b); cap_de.push_back(de_out);
  endtask

  task automatic clear_cap;
    cap_r.delete(); cap_g.delete(); cap_b.delete(); cap_de.delete();
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic test_reset;
    resetn = 1'b1; de = 1'b1; hsync = 1'b1; vsync = 1'b1;
    r_in = 8'hAA; g_in = 8'h55; b_in = 8'hC3;
    #2 resetn = 1'b0;
    #20;
    checks++; if (r !== 10'h354) begin failures++; $display("FAIL reset_r got=%h exp=354", r); end
    checks++; if (g !== 10'h354) begin failures++; $display("FAIL reset_g got=%h exp=354", g); end
    checks++; if (b !== 10'h354) begin failures++; $display("FAIL reset_b got=%h exp=354", b); end
    checks++; if (de_out !== 1'b0) begin failures++; $display("FAIL reset_de got=%b exp=0", de_out); end
    de = 1'b0; hsync = 1'b0; vsync = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    clear_cap();
    blank(6);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (cap_r[k] !== 10'h354 || cap_g[k] !== 10'h354 || cap_b[k] !== 10'h354 || cap_de[k] !== 1'b0) begin
        failures++;
        $display("FAIL post_reset[%0d] got r=%h g=%h b=%h de=%b exp 354/354/354/0", k, cap_r[k], cap_g[k], cap_b[k], cap_de[k]);
      end
    end
  endtask

  task automatic test_control;
    logic [9:0] eb;
    clear_cap();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'h12, 8'h34, 8'h56);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 8'h12, 8'h34, 8'h56);
    blank(LAT);
    for (int k = 0; k < 8; k++) begin
      eb = (k < 4) ? 10'h0AB : 10'h2AB;
      checks++;
      if (cap_b[k+LAT-1] !== eb || cap_r[k+LAT-1] !== 10'h354 || cap_g[k+LAT-1] !== 10'h354 || cap_de[k+LAT-1] !== 1'b0) begin
        failures++;
        $display("FAIL control[%0d] got b=%h r=%h g=%h de=%b exp b=%h r=354 g=354 de=0",
                 k, cap_b[k+LAT-1], cap_r[k+LAT-1], cap_g[k+LAT-1], cap_de[k+LAT-1], eb);
      end
    end
  endtask

  task automatic test_zero_run;
    logic [9:0] exp_s [4];
    exp_s = '{10'h100, 10'h3FF, 10'h100, 10'h3FF};
    clear_cap();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    blank(LAT);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cap_r[k+LAT-1] !== exp_s[k] || cap_g[k+LAT-1] !== exp_s[k] || cap_b[k+LAT-1] !== exp_s[k] || cap_de[k+LAT-1] !== 1'b1) begin
        failures++;
        $display("FAIL zero_run[%0d] got r=%h g=%h b=%h de=%b exp=%h de=1",
                 k, cap_r[k+LAT-1], cap_g[k+LAT-1], cap_b[k+LAT-1], cap_de[k+LAT-1], exp_s[k]);
      end
    end
    checks++;
    if (cap_b[4+LAT-1] !== 10'h354 || cap_de[4+LAT-1] !== 1'b0) begin
      failures++;
      $display("FAIL zero_run_end got b=%h de=%b exp b=354 de=0", cap_b[4+LAT-1], cap_de[4+LAT-1]);
    end
  endtask

  task automatic test_mixed;
    logic [9:0] er [3];
    logic [9:0] eg [3];
    logic [9:0] eb [3];
    er = '{10'h200, 10'h0FF, 10'h0FF};
    eg = '{10'h100, 10'h3FF, 10'h100};
    eb = '{10'h1FF, 10'h300, 10'h300};
    clear_cap();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h01);
    blank(LAT);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (cap_r[k+LAT-1] !== er[k] || cap_g[k+LAT-1] !== eg[k] || cap_b[k+LAT-1] !== eb[k]) begin
        failures++;
        $display("FAIL mixed[%0d] got r=%h g=%h b=%h exp r=%h g=%h b=%h",
                 k, cap_r[k+LAT-1], cap_g[k+LAT-1], cap_b[k+LAT-1], er[k], eg[k], eb[k]);
      end
    end
  endtask

  task automatic test_one_cycle_gap;
    logic [9:0] erg [5];
    logic [9:0] eb  [5];
    logic       ed  [5];
    erg = '{10'h100, 10'h3FF, 10'h100, 10'h354, 10'h100};
    eb  = '{10'h100, 10'h3FF, 10'h100, 10'h0AB, 10'h100};
    ed  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    clear_cap();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    blank(LAT);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (cap_r[k+LAT-1] !== erg[k] || cap_g[k+LAT-1] !== erg[k] || cap_b[k+LAT-1] !== eb[k] || cap_de[k+LAT-1] !== ed[k]) begin
        failures++;
        $display("FAIL gap[%0d] got r=%h g=%h b=%h de=%b exp r/g=%h b=%h de=%b",
                 k, cap_r[k+LAT-1], cap_g[k+LAT-1], cap_b[k+LAT-1], cap_de[k+LAT-1], erg[k], eb[k], ed[k]);
      end
    end
  endtask

  task automatic test_reset_midline;
    clear_cap();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checks++;
    if (b !== 10'h3FF) begin failures++; $display("FAIL midline_pre got b=%h exp=3FF", b); end
    resetn = 1'b0;
    #1;
    checks++;
    if (r !== 10'h354 || g !== 10'h354 || b !== 10'h354 || de_out !== 1'b0) begin
      failures++;
      $display("FAIL midline_reset got r=%h g=%h b=%h de=%b exp 354/354/354/0", r, g, b, de_out);
    end
    @(posedge clk); #1 resetn = 1'b1;
    clear_cap();
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    blank(LAT);
    checks++;
    if (cap_b[LAT-1] !== 10'h100 || cap_r[LAT-1] !== 10'h100 || cap_de[LAT-1] !== 1'b1) begin
      failures++;
      $display("FAIL midline_first got r=%h b=%h de=%b exp 100/100/1", cap_r[LAT-1], cap_b[LAT-1], cap_de[LAT-1]);
    end
    checks++;
    if (cap_b[LAT] !== 10'h3FF || cap_g[LAT] !== 10'h3FF) begin
      failures++;
      $display("FAIL midline_second got g=%h b=%h exp 3FF/3FF", cap_g[LAT], cap_b[LAT]);
    end
  endtask

  task automatic test_random_decode;
    logic [7:0] vr [200];
    logic [7:0] vg [200];
    logic [7:0] vb [200];
    clear_cap();
    for (int i = 0; i < 200; i++) begin
      vr[i] = 8'($urandom); vg[i] = 8'($urandom); vb[i] = 8'($urandom);
      step(1'b1, 1'b0, 1'b0, vr[i], vg[i], vb[i]);
    end
    blank(LAT);
    for (int k = 0; k < 200; k++) begin
      checks++;
      if (dec(cap_r[k+LAT-1]) !== vr[k] || dec(cap_g[k+LAT-1]) !== vg[k] || dec(cap_b[k+LAT-1]) !== vb[k] || cap_de[k+LAT-1] !== 1'b1) begin
        failures++;
        $display("FAIL decode[%0d] got r=%h g=%h b=%h de=%b exp r=%h g=%h b=%h de=1", k,
                 dec(cap_r[k+LAT-1]), dec(cap_g[k+LAT-1]), dec(cap_b[k+LAT-1]), cap_de[k+LAT-1], vr[k], vg[k], vb[k]);
      end
    end
  endtask

`ifdef TMDS_PATTERN_EN
  task automatic test_pattern;
    logic [7:0] e;
    pattern_en = 1'b1;
    clear_cap();
    for (int i = 0; i < 260; i++) step(1'b1, 1'b0, 1'b0, 8'h5A, 8'hA5, 8'h3C);
    blank(LAT);
    for (int k = 0; k < 260; k++) begin
      e = 8'(k);
      checks++;
      if (dec(cap_r[k+LAT-1]) !== e || dec(cap_g[k+LAT-1]) !== e || dec(cap_b[k+LAT-1]) !== e) begin
        failures++;
        $display("FAIL pattern[%0d] got r=%h g=%h b=%h exp=%h", k,
                 dec(cap_r[k+LAT-1]), dec(cap_g[k+LAT-1]), dec(cap_b[k+LAT-1]), e);
      end
    end
    pattern_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_control();
    test_zero_run();
    test_mixed();
    test_one_cycle_gap();
    test_reset_midline();
    test_random_decode();
`ifdef TMDS_PATTERN_EN
    test_pattern();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
